// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - dino game shared types: motion state enum and grid bit-index helper
package dino_pkg;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      HANG   = 2'd2,
      FALL   = 2'd3
   } dino_state_e;

   // Row r occupies [r*cols +: cols]; column 0 is the leftmost, i.e. the MSB of the row.
   function automatic int unsigned grid_bit(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols);
      return row * cols + (cols - 1 - col);
   endfunction

endpackage

// File: rtl/dino_edge_det.sv
// rtl/dino_edge_det.sv - rising-edge detector for the raw jump button
module dino_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic button_i,
   output logic edge_o
);

   logic jb_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jb_q <= 1'b0;
      end else begin
         jb_q <= button_i;
      end
   end

   assign edge_o = button_i & ~jb_q;

endmodule

// File: rtl/dino_jump_ctrl.sv
// rtl/dino_jump_ctrl.sv - tick-paced multi-row dino jump FSM and one-hot grid drive
// Optional DINO_JUMP_BUFFER_EN: a press during FALL is buffered and relaunches after landing.
module dino_jump_ctrl
   import dino_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 8,
   parameter int DINO_COL   = 0,
   parameter int STEP_TICKS = 1,
   parameter int HANG_TICKS = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tick,
   input  logic                     jump_button,
   output logic [ROWS*COLS-1:0]     grid,
   output logic [$clog2(ROWS)-1:0]  height,
   output logic                     airborne
);

   localparam int HW = $clog2(ROWS);
   localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam int GW = (HANG_TICKS > 1) ? $clog2(HANG_TICKS) : 1;

   localparam logic [HW-1:0] TOP_ROW   = HW'(ROWS - 1);
   localparam logic [HW-1:0] ONE_ROW   = HW'(1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
   localparam logic [GW-1:0] HANG_LAST = GW'(HANG_TICKS - 1);
   localparam logic [ROWS*COLS-1:0] GRID_ONE = {{(ROWS*COLS-1){1'b0}}, 1'b1};

   dino_state_e   state_q, state_d;
   logic [HW-1:0] height_q, height_d;
   logic [SW-1:0] step_q, step_d;
   logic [GW-1:0] hang_q, hang_d;
   logic          pend_q, pend_d;
   logic          btn_edge;
   logic          accept_press;

   dino_edge_det u_edge_det (
      .clk      (clk),
      .reset    (reset),
      .button_i (jump_button),
      .edge_o   (btn_edge)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= GROUND;
         height_q <= '0;
         step_q   <= '0;
         hang_q   <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         height_q <= height_d;
         step_q   <= step_d;
         hang_q   <= hang_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      height_d = height_q;
      step_d   = step_q;
      hang_d   = hang_q;
      pend_d   = pend_q;

`ifdef DINO_JUMP_BUFFER_EN
      accept_press = (state_q == GROUND) || (state_q == FALL);
`else
      accept_press = (state_q == GROUND);
`endif

      if (btn_edge && accept_press) begin
         pend_d = 1'b1;
      end

      // A launch clears pend after the set above, so a coincident edge is consumed.
      if (tick) begin
         case (state_q)
            GROUND: begin
               if (pend_q || btn_edge) begin
                  pend_d   = 1'b0;
                  height_d = ONE_ROW;
                  step_d   = '0;
                  hang_d   = '0;
                  state_d  = (ROWS == 2) ? HANG : RISE;
               end
            end
            RISE: begin
               if (step_q == STEP_LAST) begin
                  step_d   = '0;
                  height_d = height_q + 1'b1;
                  if (height_q + 1'b1 == TOP_ROW) begin
                     hang_d  = '0;
                     state_d = HANG;
                  end
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
            HANG: begin
               if (hang_q == HANG_LAST) begin
                  step_d  = '0;
                  state_d = FALL;
               end else begin
                  hang_d = hang_q + 1'b1;
               end
            end
            FALL: begin
               if (step_q == STEP_LAST) begin
                  step_d   = '0;
                  height_d = height_q - 1'b1;
                  if (height_q == ONE_ROW) begin
                     state_d = GROUND;
                  end
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
            default: begin
               state_d  = GROUND;
               height_d = '0;
            end
         endcase
      end
   end

   assign height   = height_q;
   assign airborne = (state_q != GROUND);
   assign grid     = GRID_ONE << grid_bit(32'(height_q), DINO_COL, COLS);

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb/tb_dino_jump_ctrl.sv - table-driven bench for dino_jump_ctrl (default and ROWS=2 builds)
module tb_dino_jump_ctrl;

`ifdef DINO_JUMP_BUFFER_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        btn = 1'b0;
   logic [31:0] grid;
   logic [1:0]  height;
   logic        airborne;

   logic        tick2 = 1'b0;
   logic        btn2 = 1'b0;
   logic [15:0] grid2;
   logic [0:0]  height2;
   logic        airborne2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dino_jump_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .jump_button (btn),
      .grid        (grid),
      .height      (height),
      .airborne    (airborne)
   );

   dino_jump_ctrl #(
      .ROWS       (2),
      .COLS       (8),
      .DINO_COL   (0),
      .STEP_TICKS (3),
      .HANG_TICKS (2)
   ) dut2 (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick2),
      .jump_button (btn2),
      .grid        (grid2),
      .height      (height2),
      .airborne    (airborne2)
   );

   typedef struct {
      logic t;
      logic b;
      int   h;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic t, input logic b, input int h);
      vec_t v;
      v.t = t;
      v.b = b;
      v.h = h;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic t, input logic b);
      @(negedge clk);
      tick = t;
      btn  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic check_main(input string nm, input int h);
      check({nm, "_h"}, 32'(height), h);
      check({nm, "_air"}, 32'(airborne), (h != 0) ? 1 : 0);
      check({nm, "_grid"}, grid, 32'h80 << (8 * h));
   endtask

   initial begin
      int n;
      int h2;

      // held-button jump: 1,2,3,3,3,2,1,0 then no second jump while still held
      add(1, 1, 1); add(1, 1, 2); add(1, 1, 3); add(1, 1, 3);
      add(1, 1, 3); add(1, 1, 2); add(1, 1, 1); add(1, 1, 0);
      for (int i = 0; i < 12; i++) add(1, 1, 0);
      for (int i = 0; i < 3; i++)  add(1, 0, 0);
      // second press lands while falling through height 2
      add(1, 1, 1); add(1, 0, 2); add(1, 0, 3); add(1, 0, 3);
      add(1, 0, 3); add(1, 0, 2);
      add(1, 1, 1);
      add(1, 0, 0);
      add(1, 0, BUF ? 1 : 0);
      add(1, 0, BUF ? 2 : 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_main("reset", 0);
      check("reset_grid2", 32'(grid2), 32'h0080);
      check("reset_air2", 32'(airborne2), 0);

      foreach (vecs[i]) begin
         cyc(vecs[i].t, vecs[i].b);
         check_main($sformatf("vec%0d", i), vecs[i].h);
      end

      // asynchronous reset while airborne at height 2
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cyc(1, 1);
      cyc(1, 0);
      check("pre_reset_h", 32'(height), 2);
      #2;
      reset = 1'b1;
      #1;
      check_main("async_reset", 0);
      @(negedge clk);
      reset = 1'b0;

      // press with tick idle: pend holds the jump until the first tick
      for (int i = 0; i < 50; i++) begin
         cyc(0, 1);
         check("idle_h", 32'(height), 0);
      end
      check("idle_air", 32'(airborne), 0);
      cyc(1, 0);
      check_main("first_tick", 1);
      for (int i = 0; i < 7; i++) cyc(1, 0);
      check_main("idle_land", 0);

      // ROWS=2, STEP_TICKS=3, tick every 4th clk
      tick = 1'b0;
      btn  = 1'b0;
      n = 0;
      for (int c = 0; c < 28; c++) begin
         @(negedge clk);
         tick2 = (c % 4 == 3);
         btn2  = (c < 5);
         @(posedge clk);
         #1;
         if (tick2) n++;
         h2 = (n >= 1 && n <= 5) ? 1 : 0;
         check("r2_h", 32'(height2), h2);
         check("r2_air", 32'(airborne2), h2);
         check("r2_grid", 32'(grid2), (h2 != 0) ? 32'h8000 : 32'h0080);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dino_jump_ctrl.md
# dino_jump_ctrl

Parametrised dinosaur vertical-motion controller for the DINO game display path. It turns a raw jump button into a multi-row jump arc (rise, hang, fall), paced by a game tick, and drives a ROWS×COLS one-hot occupancy grid consumed by the display/collision logic. It is the multi-row, tick-paced replacement for the fixed two-row dino mover.

## Interface
- ROWS, 4, grid rows; minimum 2; row 0 is ground.
- COLS, 8, grid columns; minimum 1.
- DINO_COL, 0, dino column; 0 is leftmost; must be < COLS.
- STEP_TICKS, 1, ticks per one-row move while rising or falling; minimum 1.
- HANG_TICKS, 2, extra ticks spent at the top row before falling; minimum 1.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- tick  in  1  game-rate enable, one clk wide; all motion advances only on tick.
- jump_button  in  1  raw level; only rising edges matter.
- grid  out  ROWS*COLS  row r occupies [r*COLS +: COLS]; column c is bit r*COLS + (COLS-1-c).
- height  out  $clog2(ROWS)  current dino row.
- airborne  out  1  high whenever state is not GROUND.

## Operation
- Edge detect: jb_q registered every clk (reset 0); edge = jump_button & ~jb_q. A held button gives one jump.
- pend flag: set by edge while in GROUND; cleared on launch. Edges in any other state are discarded.
- States: GROUND, RISE, HANG, FALL; step_cnt counts 0..STEP_TICKS-1, hang_cnt counts 0..HANG_TICKS-1. Nothing changes on clk edges without tick, apart from jb_q and pend.
- GROUND, tick & (pend | edge): height <= 1, step_cnt <= 0; next = HANG if ROWS==2, else RISE.
- RISE, tick: if step_cnt==STEP_TICKS-1, then step_cnt <= 0 and height <= height+1, with HANG (hang_cnt <= 0) if the new height == ROWS-1; otherwise step_cnt++.
- HANG, tick: if hang_cnt==HANG_TICKS-1, then FALL and step_cnt <= 0; otherwise hang_cnt++. The top row therefore shows for HANG_TICKS+1 ticks when STEP_TICKS=1.
- FALL, tick: on step completion height <= height-1; if old height==1, then GROUND.
- grid: combinational from height, with exactly one bit set at row height, column DINO_COL.
- height never exceeds ROWS-1 and never underflows.

## Timing
- Reset values: state GROUND, height 0, airborne 0, pend 0, counters 0, grid = 1 << (COLS-1-DINO_COL) (defaults: 32'h0000_0080).
- Launch latency: a press edge coincident with tick launches on that same clk edge. Otherwise launch occurs on the first tick after the edge.
- Reset mid-jump: immediate return to GROUND/height 0; any pending press is lost.
- tick held high continuously is legal: one step per clk.

## Configuration
- DINO_JUMP_BUFFER_EN defined: an edge during FALL also sets pend, and the dino relaunches on the first tick after landing in GROUND. Edges during RISE and HANG are still discarded.
- Undefined: edges while airborne are always discarded, so a press must occur in GROUND.

## Structure
- dino_pkg: the state enum (GROUND, RISE, HANG, FALL) and the grid bit-index function (row, col, COLS). It is shared with the obstacle and collision blocks.
- One sub-module, dino_edge_det: it holds the jb_q register and the rising-edge output.
- The FSM, counters and grid decode stay in dino_jump_ctrl.

## Test plan
- Reset with defaults, then release -> grid=32'h80, height 0, airborne 0; asserting reset mid-air at height 2 -> height 0 within the same cycle.
- Defaults, tick every clk, a single press edge at edge 0 -> height after edges 0..7 = 1,2,3,3,3,2,1,0; airborne deasserts after edge 7.
- Button held high for 20 cycles -> exactly one jump; a second press while height=2 (buffer undefined) -> no second jump.
- DINO_JUMP_BUFFER_EN defined, press during FALL at height 2 -> landing at height 0, then launch to height 1 on the next tick.
- ROWS=2, STEP_TICKS=3, tick every 4th clk -> launch goes directly to HANG at height 1, falls after 2 more ticks, grid toggles between bits 15 and 7.
- tick low for 50 cycles after a press in GROUND -> height stays 0; first tick -> height 1.
